// File: rtl/t05_decode_sequencer.sv
// Top-level run sequencer for the decode engine: header, codebook load, decoder clear, translate.
// Adds a progress watchdog and reports completion or failure with a registered error code.
module t05_decode_sequencer #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic        abort,
    input  logic        hd_done,
    input  logic        hd_error,
    input  logic [31:0] hd_tot_chars,
    input  logic        cb_done,
    input  logic        tr_finished,
    input  logic        progress,
    output logic        hd_enable,
    output logic        cb_enable,
    output logic        tr_enable,
    output logic        tr_clear,
    output logic [31:0] tot_chars,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_CODEBOOK,
        S_CLEAR,
        S_TRANSLATE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_HEADER  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  err_nxt;
    logic        tot_load;
    logic [23:0] wdog;
    logic        timed_state;
    logic        wdog_expired;

    // Next-state decision; abort outranks phase-complete events, which outrank the watchdog.
    always_comb begin
        timed_state  = (state == S_HEADER) || (state == S_CODEBOOK) || (state == S_TRANSLATE);
        wdog_expired = timed_state && !progress && (wdog >= (TIMEOUT_CYCLES - 24'd1));
        state_nxt    = state;
        err_nxt      = err_code;
        tot_load     = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_nxt = S_HEADER;
                    err_nxt   = ERR_NONE;
                end
            end
            S_HEADER: begin
                if (abort) begin
                    state_nxt = S_ERROR;
                    err_nxt   = ERR_ABORT;
                end else if (hd_done) begin
                    if (hd_error) begin
                        state_nxt = S_ERROR;
                        err_nxt   = ERR_HEADER;
                    end else begin
                        tot_load  = 1'b1;
                        state_nxt = (hd_tot_chars == 32'd0) ? S_DONE : S_CODEBOOK;
                    end
                end else if (wdog_expired) begin
                    state_nxt = S_ERROR;
                    err_nxt   = ERR_TIMEOUT;
                end
            end
            S_CODEBOOK: begin
                if (abort) begin
                    state_nxt = S_ERROR;
                    err_nxt   = ERR_ABORT;
                end else if (cb_done) begin
                    state_nxt = S_CLEAR;
                end else if (wdog_expired) begin
                    state_nxt = S_ERROR;
                    err_nxt   = ERR_TIMEOUT;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_nxt = S_ERROR;
                    err_nxt   = ERR_ABORT;
                end else begin
                    state_nxt = S_TRANSLATE;
                end
            end
            S_TRANSLATE: begin
                if (abort) begin
                    state_nxt = S_ERROR;
                    err_nxt   = ERR_ABORT;
                end else if (tr_finished) begin
                    state_nxt = S_DONE;
                end else if (wdog_expired) begin
                    state_nxt = S_ERROR;
                    err_nxt   = ERR_TIMEOUT;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                err_nxt   = ERR_NONE;
            end
        endcase
    end

    // Outputs are registered from the next state so they always agree with the state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= S_IDLE;
            err_code  <= ERR_NONE;
            tot_chars <= 32'd0;
            wdog      <= 24'd0;
            hd_enable <= 1'b0;
            cb_enable <= 1'b0;
            tr_enable <= 1'b0;
            tr_clear  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state    <= state_nxt;
            err_code <= err_nxt;
            if (tot_load) begin
                tot_chars <= hd_tot_chars;
            end
            // Saturating counter; cleared by any activity or any state change.
            if ((state_nxt != state) || progress) begin
                wdog <= 24'd0;
            end else if (timed_state && (wdog != 24'hFF_FFFF)) begin
                wdog <= wdog + 24'd1;
            end
            hd_enable <= (state_nxt == S_HEADER);
            cb_enable <= (state_nxt == S_CODEBOOK);
            tr_enable <= (state_nxt == S_TRANSLATE);
            tr_clear  <= (state_nxt == S_CLEAR);
            busy      <= (state_nxt == S_HEADER) || (state_nxt == S_CODEBOOK) ||
                         (state_nxt == S_CLEAR)  || (state_nxt == S_TRANSLATE);
            done      <= (state_nxt == S_DONE);
            error     <= (state_nxt == S_ERROR);
        end
    end

endmodule

// File: tb/tb_t05_decode_sequencer.sv
// Scenario bench for t05_decode_sequencer with a 16-cycle watchdog; expected output
// vectors are queued as stimulus is applied and compared after each clock edge.
module tb_t05_decode_sequencer;

    localparam int M_IDLE = 0;
    localparam int M_HEADER = 1;
    localparam int M_CODEBOOK = 2;
    localparam int M_CLEAR = 3;
    localparam int M_TRANSLATE = 4;
    localparam int M_DONE = 5;
    localparam int M_ERROR = 6;

    typedef struct {
        string        name;
        logic [40:0]  v;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        hd_done = 1'b0;
    logic        hd_error = 1'b0;
    logic [31:0] hd_tot_chars = 32'd0;
    logic        cb_done = 1'b0;
    logic        tr_finished = 1'b0;
    logic        progress = 1'b0;
    logic        hd_enable, cb_enable, tr_enable, tr_clear, busy, done, error;
    logic [31:0] tot_chars;
    logic [1:0]  err_code;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail = 0;
    logic seen_cb = 1'b0;
    logic seen_tr = 1'b0;
    logic seen_clr = 1'b0;

    t05_decode_sequencer #(.TIMEOUT_CYCLES(24'd16)) dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .hd_done(hd_done), .hd_error(hd_error), .hd_tot_chars(hd_tot_chars),
        .cb_done(cb_done), .tr_finished(tr_finished), .progress(progress),
        .hd_enable(hd_enable), .cb_enable(cb_enable), .tr_enable(tr_enable),
        .tr_clear(tr_clear), .tot_chars(tot_chars), .busy(busy), .done(done),
        .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cb_enable) seen_cb = 1'b1;
        if (tr_enable) seen_tr = 1'b1;
        if (tr_clear) seen_clr = 1'b1;
    end

    // Output vector implied by a state of the sequencer, independent of the DUT.
    function automatic exp_t mk(string n, int st, logic [1:0] ec, logic [31:0] tc);
        exp_t e;
        e.name = n;
        e.v = {st == M_HEADER, st == M_CODEBOOK, st == M_TRANSLATE, st == M_CLEAR,
               (st >= M_HEADER) && (st <= M_TRANSLATE), st == M_DONE, st == M_ERROR, ec, tc};
        return e;
    endfunction

    function automatic logic [40:0] dut_out();
        return {hd_enable, cb_enable, tr_enable, tr_clear, busy, done, error, err_code, tot_chars};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        sb.push_back(mk("reset_async", M_IDLE, 2'b00, 32'd0));
        #3;
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        step();
        step();
        nrst = 1'b1;
        sb.push_back(mk("reset_idle_wait", M_IDLE, 2'b00, 32'd0));
        step();
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
    endtask

    task automatic test_nominal();
        exp_t e;
        start = 1'b1;
        sb.push_back(mk("nom_header", M_HEADER, 2'b00, 32'd0));
        step();
        start = 1'b0;
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        repeat (3) step();
        hd_done = 1'b1; hd_tot_chars = 32'd5;
        sb.push_back(mk("nom_codebook", M_CODEBOOK, 2'b00, 32'd5));
        step();
        hd_done = 1'b0; hd_tot_chars = 32'hDEAD_BEEF;
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        repeat (9) step();
        cb_done = 1'b1;
        sb.push_back(mk("nom_clear", M_CLEAR, 2'b00, 32'd5));
        step();
        cb_done = 1'b0;
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        sb.push_back(mk("nom_translate", M_TRANSLATE, 2'b00, 32'd5));
        step();
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        for (int i = 0; i < 198; i++) begin
            progress = (i % 8 == 7);
            step();
        end
        progress = 1'b0;
        sb.push_back(mk("nom_translate_hold", M_TRANSLATE, 2'b00, 32'd5));
        step();
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        tr_finished = 1'b1;
        sb.push_back(mk("nom_done", M_DONE, 2'b00, 32'd5));
        step();
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        cb_done = 1'b1; abort = 1'b1;
        repeat (3) step();
        cb_done = 1'b0; abort = 1'b0; tr_finished = 1'b0;
        sb.push_back(mk("nom_done_hold", M_DONE, 2'b00, 32'd5));
        step();
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
    endtask

    task automatic test_header_error();
        exp_t e;
        seen_cb = 1'b0;
        start = 1'b1;
        sb.push_back(mk("herr_header", M_HEADER, 2'b00, 32'd5));
        step();
        start = 1'b0;
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        hd_done = 1'b1; hd_error = 1'b1; hd_tot_chars = 32'd5;
        sb.push_back(mk("herr_error", M_ERROR, 2'b01, 32'd5));
        step();
        hd_done = 1'b0; hd_error = 1'b0;
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        cb_done = 1'b1;
        step();
        cb_done = 1'b0;
        sb.push_back(mk("herr_hold", M_ERROR, 2'b01, 32'd5));
        step();
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        n_assert++;
        if (seen_cb !== 1'b0) begin n_fail++; $display("FAIL herr_no_cb_enable: got %b expected 0", seen_cb); end
        start = 1'b1;
        sb.push_back(mk("herr_restart", M_HEADER, 2'b00, 32'd5));
        step();
        start = 1'b0;
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
    endtask

    task automatic test_zero_chars();
        exp_t e;
        seen_cb = 1'b0; seen_tr = 1'b0;
        hd_done = 1'b1; hd_tot_chars = 32'd0;
        sb.push_back(mk("zero_done", M_DONE, 2'b00, 32'd0));
        step();
        hd_done = 1'b0;
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        repeat (2) step();
        n_assert++;
        if ({seen_cb, seen_tr} !== 2'b00) begin n_fail++; $display("FAIL zero_no_cb_tr: got %b expected 00", {seen_cb, seen_tr}); end
        // start held high relaunches exactly once per completion
        start = 1'b1;
        sb.push_back(mk("relaunch_1", M_HEADER, 2'b00, 32'd0));
        step();
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        hd_done = 1'b1;
        sb.push_back(mk("relaunch_done", M_DONE, 2'b00, 32'd0));
        step();
        hd_done = 1'b0;
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        sb.push_back(mk("relaunch_2", M_HEADER, 2'b00, 32'd0));
        step();
        start = 1'b0;
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
    endtask

    task automatic test_timeout();
        exp_t e;
        hd_done = 1'b1; hd_tot_chars = 32'd7;
        step();
        hd_done = 1'b0;
        cb_done = 1'b1;
        step();
        cb_done = 1'b0;
        sb.push_back(mk("to_translate", M_TRANSLATE, 2'b00, 32'd7));
        step();
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        repeat (3) begin
            progress = 1'b1;
            step();
            progress = 1'b0;
            repeat (9) step();
        end
        sb.push_back(mk("to_hold_10", M_TRANSLATE, 2'b00, 32'd7));
        step();
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        repeat (4) step();
        sb.push_back(mk("to_hold_15", M_TRANSLATE, 2'b00, 32'd7));
        step();
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        sb.push_back(mk("to_expired_16", M_ERROR, 2'b10, 32'd7));
        step();
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
    endtask

    task automatic test_collision();
        exp_t e;
        start = 1'b1;
        step();
        start = 1'b0;
        hd_done = 1'b1; hd_tot_chars = 32'd3;
        sb.push_back(mk("col_codebook", M_CODEBOOK, 2'b00, 32'd3));
        step();
        hd_done = 1'b0;
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        repeat (15) step();
        cb_done = 1'b1;
        sb.push_back(mk("col_cb_vs_wdog", M_CLEAR, 2'b00, 32'd3));
        step();
        cb_done = 1'b0;
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        step();
        abort = 1'b1; tr_finished = 1'b1;
        sb.push_back(mk("col_abort_vs_fin", M_ERROR, 2'b11, 32'd3));
        step();
        tr_finished = 1'b0;
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        sb.push_back(mk("col_abort_in_error", M_ERROR, 2'b11, 32'd3));
        step();
        abort = 1'b0;
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        start = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b1; hd_done = 1'b1; hd_tot_chars = 32'd8;
        sb.push_back(mk("col_abort_vs_hd", M_ERROR, 2'b11, 32'd3));
        step();
        abort = 1'b0; hd_done = 1'b0;
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        start = 1'b1;
        step();
        start = 1'b0;
        hd_done = 1'b1; hd_tot_chars = 32'd4;
        step();
        hd_done = 1'b0;
        cb_done = 1'b1;
        step();
        cb_done = 1'b0;
        sb.push_back(mk("rst_translate", M_TRANSLATE, 2'b00, 32'd4));
        step();
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        seen_clr = 1'b0;
        #2;
        nrst = 1'b0;
        sb.push_back(mk("rst_async_midcycle", M_IDLE, 2'b00, 32'd0));
        #2;
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        step();
        nrst = 1'b1;
        repeat (3) step();
        sb.push_back(mk("rst_idle_after", M_IDLE, 2'b00, 32'd0));
        step();
        e = sb.pop_front(); n_assert++;
        if (dut_out() !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, dut_out(), e.v); end
        n_assert++;
        if (seen_clr !== 1'b0) begin n_fail++; $display("FAIL rst_no_tr_clear: got %b expected 0", seen_clr); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_header_error();
        test_zero_chars();
        test_timeout();
        test_collision();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/t05_decode_sequencer.md
T05_DECODE_SEQUENCER -- requirements
Module: t05_decode_sequencer

Interface
REQ-001: Parameter TIMEOUT_CYCLES, default 24'd1_000_000, watchdog limit in clk cycles without progress.
REQ-002: clk  input  1  system clock; all state changes on its rising edge.
REQ-003: nrst  input  1  asynchronous, active-low reset.
REQ-004: start  input  1  level; launches a decode run when sampled high in IDLE, DONE or ERROR.
REQ-005: abort  input  1  level; cancels any active run.
REQ-006: hd_done  input  1  header-decode phase complete, one-cycle pulse.
REQ-007: hd_error  input  1  header malformed; valid only with hd_done.
REQ-008: hd_tot_chars  input  32  character count from header; valid only with hd_done.
REQ-009: cb_done  input  1  codebook load into SRAM complete, one-cycle pulse.
REQ-010: tr_finished  input  1  level from the translation decoder; all characters written.
REQ-011: progress  input  1  activity strobe (any SPI read/write enable), restarts watchdog.
REQ-012: hd_enable, cb_enable, tr_enable  output  1 each  phase enables.
REQ-013: tr_clear  output  1  one-cycle clear for translation-decoder state.
REQ-014: tot_chars  output  32  latched character count for the translation decoder.
REQ-015: busy  output  1  high in HEADER, CODEBOOK, CLEAR, TRANSLATE.
REQ-016: done  output  1  high in DONE.
REQ-017: error  output  1  high in ERROR.
REQ-018: err_code  output  2  00 none, 01 header error, 10 timeout, 11 abort.

Function
REQ-019: States IDLE, HEADER, CODEBOOK, CLEAR, TRANSLATE, DONE, ERROR; all outputs are registered or decoded from the state register only (Moore); no input-to-output combinational path.
REQ-020: IDLE/DONE/ERROR + start=1 -> HEADER next edge; hd_enable high the cycle after start is sampled; err_code cleared to 00 on that transition.
REQ-021: HEADER + hd_done with hd_error=1 -> ERROR, err_code=01.
REQ-022: HEADER + hd_done with hd_error=0, hd_tot_chars=0 -> DONE, tot_chars=0; CODEBOOK and TRANSLATE skipped.
REQ-023: HEADER + hd_done with hd_error=0, hd_tot_chars!=0 -> CODEBOOK; tot_chars latched from hd_tot_chars on that edge and held until the next accepted hd_done or reset.
REQ-024: CODEBOOK + cb_done -> CLEAR; CLEAR lasts exactly one cycle (tr_clear=1) -> TRANSLATE.
REQ-025: TRANSLATE: tr_enable=1; tr_finished=1 -> DONE.
REQ-026: Exactly one of hd_enable, cb_enable, tr_enable, tr_clear is high in HEADER, CODEBOOK, TRANSLATE, CLEAR respectively; all low otherwise.
REQ-027: Watchdog counter, 24 bits, zeroed on every state transition and on every cycle with progress=1; increments each cycle in HEADER, CODEBOOK, TRANSLATE; reaching TIMEOUT_CYCLES-1 without reset -> ERROR, err_code=10; never wraps.
REQ-028: abort=1 in any busy state -> ERROR, err_code=11 next edge; abort ignored in IDLE, DONE, ERROR.
REQ-029: Priority on the same cycle: abort > phase-complete event (hd_done, cb_done, tr_finished) > watchdog expiry.
REQ-030: hd_done, cb_done, tr_finished ignored outside their own state.
REQ-031: DONE and ERROR hold indefinitely (done/error/err_code stable) until start=1; start held high continuously from DONE relaunches once per completion.

Reset
REQ-032: nrst=0 forces immediately (asynchronously) state=IDLE, all enables/tr_clear/busy/done/error=0, err_code=00, tot_chars=0, watchdog=0.
REQ-033: Reset asserted mid-run abandons the run with no tr_clear pulse; after release the block waits in IDLE for start.

Verification
REQ-034: Nominal: start; hd_done with tot_chars=5; cb_done 10 cycles later; tr_finished 200 cycles later -> states HEADER, CODEBOOK, CLEAR (one-cycle tr_clear), TRANSLATE, DONE; tot_chars=5; done=1, err_code=00.
REQ-035: Header error: hd_done with hd_error=1 -> ERROR, err_code=01, no cb_enable ever high; then start -> HEADER, err_code=00.
REQ-036: Zero chars: hd_done with hd_tot_chars=0 -> DONE next edge, cb_enable and tr_enable never high.
REQ-037: Timeout (TIMEOUT_CYCLES=16): TRANSLATE with progress pulsing every 10 cycles holds; progress stopped -> ERROR, err_code=10, 16 cycles after last progress.
REQ-038: Collision: abort and tr_finished same cycle -> ERROR, err_code=11; cb_done and watchdog expiry same cycle -> CLEAR.
REQ-039: Reset in TRANSLATE: nrst low mid-cycle -> all outputs 0 before the next clk edge; tot_chars=0.
